// File: rtl/avr_memsys_if.sv
// Data-port bus between the AVR core (master) and the memory subsystem (slave).
// Carries the request, the write byte, the read byte, the ready pulse and the error flag.
interface avr_memsys_if;
   logic [15:0] address;
   logic        rd;
   logic        w;
   logic [7:0]  wb;
   logic [7:0]  din;
   logic        ready;
   logic        err;

   modport master (
      output address, rd, w, wb,
      input  din, ready, err
   );

   modport slave (
      input  address, rd, w, wb,
      output din, ready, err
   );
endinterface

// File: rtl/avr_memsys.sv
// AVR memory subsystem: word-wide program flash with loader port, and byte-wide data RAM
// with low/high mapped windows behind a wait-state handshake and a sticky unmapped flag.
module avr_memsys #(
   parameter int unsigned PC_WIDTH    = 12,
   parameter int unsigned LO_END      = 16'h17FF,
   parameter int unsigned HI_BASE     = 16'h8000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [15:0]         pc,
   output logic [15:0]         ir,
   output logic                ir_valid,
   input  logic                load_en,
   input  logic [PC_WIDTH-1:0] load_addr,
   input  logic [15:0]         load_data,
   avr_memsys_if.slave         bus
);

   localparam int unsigned FLASH_DEPTH = 1 << PC_WIDTH;
   localparam int unsigned RAM_DEPTH   = LO_END + 1 + 65536 - HI_BASE;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [15:0] flash [FLASH_DEPTH];
   logic [7:0]  ram   [RAM_DEPTH];

   // ---------------- fetch path ----------------
   logic pc_in_range;

   assign pc_in_range = ((32'(pc) >> PC_WIDTH) == 32'd0);

   always_ff @(posedge clock) begin
      if (load_en) begin
         flash[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ir       <= 16'h0000;
         ir_valid <= 1'b0;
      end else if (load_en || !pc_in_range) begin
         ir       <= 16'h0000;
         ir_valid <= 1'b0;
      end else begin
         ir       <= flash[pc[PC_WIDTH-1:0]];
         ir_valid <= 1'b1;
      end
   end

   // ---------------- data path ----------------
   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wb_q, wb_d;
   logic        op_q, op_d;
   logic [7:0]  din_q;
   logic        err_q;

   logic        do_access;
   logic [15:0] cur_addr;
   logic [7:0]  cur_wb;
   logic        cur_op;
   logic        cur_lo;
   logic        cur_mapped;
   logic [15:0] cur_idx;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wb_d      = wb_q;
      op_d      = op_q;
      do_access = 1'b0;
      cur_addr  = addr_q;
      cur_wb    = wb_q;
      cur_op    = op_q;
      case (state_q)
         S_IDLE: begin
            if (bus.rd || bus.w) begin
               addr_d   = bus.address;
               wb_d     = bus.wb;
               op_d     = bus.w;
               // With no wait states the access happens on the accepting edge itself.
               cur_addr = bus.address;
               cur_wb   = bus.wb;
               cur_op   = bus.w;
               if (WAIT_STATES == 0) begin
                  do_access = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  cnt_d   = 4'(WAIT_STATES - 1);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               do_access = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // High window is packed right after the low window in the storage array.
   assign cur_lo     = (cur_addr <= 16'(LO_END));
   assign cur_mapped = cur_lo || (cur_addr >= 16'(HI_BASE));
   assign cur_idx    = cur_lo ? cur_addr : 16'(32'(cur_addr) + LO_END + 1 - HI_BASE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 16'h0000;
         wb_q    <= 8'h00;
         op_q    <= 1'b0;
         din_q   <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wb_q    <= wb_d;
         op_q    <= op_d;
         if (do_access) begin
            if (cur_mapped) begin
               din_q <= ram[cur_idx];
            end else begin
               din_q <= 8'hFF;
               err_q <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && do_access && cur_op && cur_mapped) begin
         ram[cur_idx] <= cur_wb;
      end
   end

   assign bus.din   = din_q;
   assign bus.err   = err_q;
   assign bus.ready = (state_q == S_DONE);

endmodule
